// File: rtl/divu_pkg.sv
// Shared types and constants for the unsigned restoring divider control.
package divu_pkg;

  localparam int DIVU_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    FIX,
    DONE
  } divu_state_t;

endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter for the divider; saturates at WIDTH-1 by holding en low.
module div_iter_counter
  import divu_pkg::*;
#(
  parameter int WIDTH = DIVU_WIDTH,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign last = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/divu_ctrl.sv
// Control FSM for the unsigned restoring divider (LOAD, WIDTH ITERs, FIX).
// Optional zero-divisor short cut enabled by DIV0_CHECK_EN.
module divu_ctrl
  import divu_pkg::*;
#(
  parameter int WIDTH = DIVU_WIDTH,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [WIDTH-1:0] divisor,
  output logic             w_ctrl_reg1,
  output logic             w_ctrl_reg2,
  output logic             SRL_ctrl,
  output logic             busy,
  output logic             rdy,
  output logic [CW-1:0]    count,
  output logic             div0
);

  divu_state_t state, next;
  logic clr, en, last;

  div_iter_counter #(
    .WIDTH(WIDTH),
    .CW   (CW)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .en   (en),
    .count(count),
    .last (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    clr  = 1'b0;
    en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (run) begin
          next = LOAD;
          clr  = 1'b1;
        end
      end
      LOAD: begin
        next = ITER;
`ifdef DIV0_CHECK_EN
        if (divisor == '0) next = DONE;
`endif
      end
      ITER: begin
        if (last) next = FIX;
        else      en   = 1'b1;
      end
      FIX:  next = DONE;
      DONE: if (!run) next = IDLE;
      default: next = IDLE;
    endcase
  end

  assign w_ctrl_reg1 = (state == LOAD);
  assign w_ctrl_reg2 = (state == LOAD);
  assign SRL_ctrl    = (state == FIX);
  assign busy        = (state == LOAD) || (state == ITER) || (state == FIX);
  assign rdy         = (state == DONE);

`ifdef DIV0_CHECK_EN
  // Cleared on entry to LOAD, decided on exit so it stays valid through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div0 <= 1'b0;
    end else if (state == IDLE && run) begin
      div0 <= 1'b0;
    end else if (state == LOAD) begin
      div0 <= (divisor == '0);
    end
  end
`else
  logic divisor_unused;
  assign divisor_unused = ^divisor;
  assign div0           = 1'b0;
`endif

endmodule

// File: tb/tb_divu_ctrl.sv
// Directed bench for divu_ctrl with a behavioural restoring datapath.
module tb_divu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [31:0] divisor = '0;
  logic [31:0] dividend = '0;
  logic        w1, w2, srl, busy, rdy, div0;
  logic [5:0]  count;

  logic        run8 = 1'b0;
  logic [7:0]  divisor8 = 8'd3;
  logic        w1_8, w2_8, srl_8, busy_8, rdy_8, div0_8;
  logic [3:0]  count8;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  divu_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .divisor(divisor),
    .w_ctrl_reg1(w1), .w_ctrl_reg2(w2), .SRL_ctrl(srl),
    .busy(busy), .rdy(rdy), .count(count), .div0(div0)
  );

  divu_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .run(run8), .divisor(divisor8),
    .w_ctrl_reg1(w1_8), .w_ctrl_reg2(w2_8), .SRL_ctrl(srl_8),
    .busy(busy_8), .rdy(rdy_8), .count(count8), .div0(div0_8)
  );

  // Restoring datapath sampling controls on the falling edge.
  logic [64:0] rem;
  logic [31:0] dreg;
  logic [32:0] up;
  always @(negedge clk) begin
    up = rem[64:32];
    if (w2) rem <= {33'b0, dividend} << 1;
    else if (srl) rem <= {up >> 1, rem[31:0]};
    else if (up >= {1'b0, dreg}) rem <= ({up - {1'b0, dreg}, rem[31:0]} << 1) | 65'd1;
    else rem <= rem << 1;
    if (w1) dreg <= divisor;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] ctl();
    return {w1, w2, srl, busy, rdy, div0};
  endfunction

  int n, loads, lows, mx;

  initial begin
    #1;
    chk("reset_ctl", 64'(ctl()), 64'h0);
    chk("reset_count", 64'(count), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_ctl", 64'(ctl()), 64'h0);

    // Basic sequence plus 100/7 through the datapath
    dividend = 32'd100;
    divisor  = 32'd7;
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("load_ctl", 64'(ctl()), 64'b110100);
    chk("load_count", 64'(count), 64'd0);
    for (int i = 0; i < 32; i++) begin
      tick();
      chk($sformatf("iter_ctl_%0d", i), 64'(ctl()), 64'b000100);
      chk($sformatf("iter_cnt_%0d", i), 64'(count), 64'(i));
    end
    tick();
    chk("fix_ctl", 64'(ctl()), 64'b001100);
    chk("fix_count", 64'(count), 64'd31);
    tick();
    chk("done_ctl", 64'(ctl()), 64'b000010);
    chk("quot_100_7", 64'(rem[31:0]), 64'd14);
    chk("rem_100_7", 64'(rem[63:32]), 64'd2);
    tick();
    chk("back_idle", 64'(ctl()), 64'h0);

    // Held run with 0xFFFFFFFF / 1
    dividend = 32'hFFFF_FFFF;
    divisor  = 32'd1;
    run = 1'b1;
    n = 0;
    loads = 0;
    tick();
    while (!rdy && n < 40) begin
      loads += int'(w1);
      tick();
      n++;
    end
    chk("held_latency", 64'(n), 64'd34);
    chk("quot_ff_1", 64'(rem[31:0]), 64'hFFFF_FFFF);
    chk("rem_ff_1", 64'(rem[63:32]), 64'd0);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      loads += int'(w1);
      lows += int'(!rdy || busy);
    end
    chk("held_loads", 64'(loads), 64'd1);
    chk("held_done", 64'(lows), 64'd0);
    run = 1'b0;
    tick();
    chk("release_idle", 64'(ctl()), 64'h0);
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("restart_load", 64'(ctl()), 64'b110100);

    // Asynchronous reset at count 10
    for (int i = 0; i < 11; i++) tick();
    chk("pre_rst_count", 64'(count), 64'd10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ctl", 64'(ctl()), 64'h0);
    chk("async_rst_count", 64'(count), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 64'({ctl(), count}), 64'h0);

`ifdef DIV0_CHECK_EN
    divisor = 32'd0;
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("d0_load", 64'(w1), 64'd1);
    tick();
    chk("d0_done", 64'(ctl()), 64'b000011);
    tick();
    divisor = 32'd5;
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("d0_clear", 64'({w1, div0}), 64'b10);
    for (int i = 0; i < 40; i++) tick();
`else
    divisor = 32'd0;
    run = 1'b1;
    n = 0;
    tick();
    run = 1'b0;
    while (!rdy && n < 40) begin
      tick();
      n++;
    end
    chk("zero_div_full_run", 64'(n), 64'd34);
    chk("div0_tied", 64'(div0), 64'd0);
    tick();
`endif

    // WIDTH=8 instance
    run8 = 1'b1;
    tick();
    run8 = 1'b0;
    n = 0;
    mx = 0;
    while (!rdy_8 && n < 20) begin
      tick();
      n++;
      if (int'(count8) > mx) mx = int'(count8);
    end
    chk("w8_latency", 64'(n), 64'd10);
    chk("w8_peak", 64'(mx), 64'd7);
    chk("w8_exclusive", 64'({rdy_8, busy_8}), 64'b10);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
